dclk_rx: RTL

DCLK_RX -- requirements
Module: dclk_rx

---
 rtl/dclk_rx.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/dclk_rx.sv
// dclk_rx: serial-to-parallel receiver for one flit per frame.
//
// A frame is one start bit (1) followed by W data bits, LSB first. The idle
// line is 0. A received word goes into a one-entry output buffer. If that
// buffer is still occupied, the word waits in the shift register (HOLD) and
// channel_busy keeps the transmitter from starting another frame.
//
// Parameters:
//   routerid     - router index, used only in elaboration messages
//   port         - port label, used only in elaboration messages
//   W (derived)  - flit width = HDR_SZ + PL_SZ + ADDR_SZ, must be >= 4
//
// Ports:
//   clk          - clock
//   reset        - synchronous, active-high reset
//   serial_in    - serial line from the upstream transmitter (same clk domain)
//   channel_busy - high while a frame is shifting in or a word is held
//   parallel_out - received flit, stable while out_valid is high
//   out_valid    - parallel_out holds an unconsumed flit
//   out_ack      - consumer takes the flit when out_valid & out_ack
//   rx_active    - high while frame bits are being shifted in
//   overrun      - sticky flag: transmitter sent while a word was held

`ifndef HDR_SZ
`define HDR_SZ 2
`endif
`ifndef PL_SZ
`define PL_SZ 4
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 2
`endif

module dclk_rx #(
  parameter int    routerid = -1,
  parameter string port     = "unknown",
  localparam int   W        = `HDR_SZ + `PL_SZ + `ADDR_SZ
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         serial_in,
  output logic         channel_busy,
  output logic [W-1:0] parallel_out,
  output logic         out_valid,
  input  logic         out_ack,
  output logic         rx_active,
  output logic         overrun
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  if (W < 4) begin : g_width_check
    $error("dclk_rx router %0d port %s: flit width %0d is below 4", routerid, port, W);
  end

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t         state;
  state_t         state_next;
  logic [W-1:0]   shift_reg;
  logic [W-1:0]   shift_word;
  logic [W-1:0]   load_word;
  logic [CW-1:0]  count;
  logic           load_buf;
  logic           take;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and buffer-load decisions.
  // A finished word goes straight into the buffer if the buffer is empty or is
  // being emptied this same cycle. Otherwise the word parks in the shift
  // register until the consumer acks.
  always_comb begin
    state_next = state;
    load_buf   = 1'b0;
    take       = out_valid & out_ack;
    shift_word = {serial_in, shift_reg[W-1:1]};
    load_word  = shift_word;
    case (state)
      IDLE: begin
        if (serial_in) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (count == LAST_BIT) begin
          if (!out_valid || out_ack) begin
            load_buf   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (take) begin
          load_buf   = 1'b1;
          load_word  = shift_reg;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: shift register, bit counter, output buffer and overrun flag.
  // An ack and a load in the same cycle leave out_valid high with the new word.
  // Bits arriving while a word is held are dropped and flagged as overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= '0;
      shift_reg    <= '0;
      parallel_out <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (state == IDLE && serial_in) begin
        count <= '0;
      end else if (state == SHIFT) begin
        shift_reg <= shift_word;
        count     <= count + 1'b1;
      end

      if (load_buf) begin
        parallel_out <= load_word;
        out_valid    <= 1'b1;
      end else if (take) begin
        out_valid <= 1'b0;
      end

      if (state == HOLD && serial_in) begin
        overrun <= 1'b1;
      end
    end
  end

  assign channel_busy = (state == SHIFT) | (state == HOLD);
  assign rx_active    = (state == SHIFT);

endmodule
